// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage:
//   - result-source codes
//   - load funct3 codes
//   - FSM state type
package wb_pkg;

   // Result-source selector carried with each retiring instruction
   localparam logic [2:0] W_ALU  = 3'd0;
   localparam logic [2:0] W_LINK = 3'd1;
   localparam logic [2:0] W_LOAD = 3'd2;
   localparam logic [2:0] W_NONE = 3'd3;
   localparam logic [2:0] W_CSR  = 3'd4;

   // Load funct3 encodings
   localparam logic [2:0] LD_B  = 3'd0;
   localparam logic [2:0] LD_H  = 3'd1;
   localparam logic [2:0] LD_W  = 3'd2;
   localparam logic [2:0] LD_D  = 3'd3;
   localparam logic [2:0] LD_BU = 3'd4;
   localparam logic [2:0] LD_HU = 3'd5;
   localparam logic [2:0] LD_WU = 3'd6;

   typedef enum logic {
      S_IDLE     = 1'b0,
      S_WAIT_MEM = 1'b1
   } wb_state_t;

   // Non-load result types that produce a register write.
   // Codes 3 and 5..7 retire without writing.
   function automatic logic writes_rf(input logic [2:0] w_type);
      return (w_type == W_ALU) || (w_type == W_LINK) || (w_type == W_CSR);
   endfunction

endpackage

// File: rtl/wb_load_align.sv
// Combinational load data aligner.
// Picks the byte/half/word lane out of a raw aligned memory word and
// sign- or zero-extends it to XLEN. LD, LWU on XLEN=32 and the unused
// funct3 7 pass the word through untouched. Misaligned offsets are not
// checked; the lane index simply drops the low address bits.
module wb_load_align
   import wb_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]                 fmt,
   input  logic [$clog2(XLEN/8)-1:0]  addr_lo,
   input  logic [XLEN-1:0]            rdata,
   output logic [XLEN-1:0]            result
);

   localparam int AW_LO = $clog2(XLEN/8);
   localparam int NB    = XLEN / 8;
   localparam int NH    = XLEN / 16;

   logic [7:0]      byte_lane [NB];
   logic [15:0]     half_lane [NH];
   logic [7:0]      byte_sel;
   logic [15:0]     half_sel;
   logic [XLEN-1:0] word_sx;
   logic [XLEN-1:0] word_zx;

   genvar gi;

   // Split the raw word into byte lanes
   generate
      for (gi = 0; gi < NB; gi++) begin : g_byte
         assign byte_lane[gi] = rdata[gi*8 +: 8];
      end
   endgenerate

   // Split the raw word into halfword lanes
   generate
      for (gi = 0; gi < NH; gi++) begin : g_half
         assign half_lane[gi] = rdata[gi*16 +: 16];
      end
   endgenerate

   assign byte_sel = byte_lane[addr_lo];
   assign half_sel = half_lane[addr_lo[AW_LO-1:1]];

   // Word lanes only exist on RV64; on RV32 a word is the whole bus
   generate
      if (XLEN == 64) begin : g_w64
         logic [31:0] w_sel;
         assign w_sel   = addr_lo[2] ? rdata[63:32] : rdata[31:0];
         assign word_sx = {{32{w_sel[31]}}, w_sel};
         assign word_zx = {32'd0, w_sel};
      end else begin : g_w32
         assign word_sx = rdata;
         assign word_zx = rdata;
      end
   endgenerate

   // Extend the selected lane according to funct3
   always_comb begin
      result = rdata;
      case (fmt)
         LD_B:    result = {{(XLEN-8){byte_sel[7]}}, byte_sel};
         LD_H:    result = {{(XLEN-16){half_sel[15]}}, half_sel};
         LD_W:    result = word_sx;
         LD_BU:   result = {{(XLEN-8){1'b0}}, byte_sel};
         LD_HU:   result = {{(XLEN-16){1'b0}}, half_sel};
         LD_WU:   result = word_zx;
         default: result = rdata;
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// Registered, handshaked writeback stage.
// Accepts one retiring instruction per cycle. Non-loads write back on the
// following cycle. Loads park the stage in WAIT_MEM until mem_rvalid
// returns the data, then write back on the following cycle.
// Optional feature macro: WB_INSTRET_EN (64-bit retired-instruction counter).
module wb_stage
   import wb_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int LINK_INC = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [4:0]                  in_rd,
   input  logic [2:0]                  in_w_type,
   input  logic [2:0]                  in_ld_fmt,
   input  logic [$clog2(XLEN/8)-1:0]   in_addr_lo,
   input  logic [XLEN-1:0]             in_rd_data,
   input  logic [XLEN-1:0]             in_pc,
   input  logic [XLEN-1:0]             in_csr_data,
   input  logic                        mem_rvalid,
   input  logic [XLEN-1:0]             mem_rdata,
   output logic                        rf_we,
   output logic [4:0]                  rf_waddr,
   output logic [XLEN-1:0]             rf_wdata,
   output logic                        retired,
   output logic [63:0]                 instret
);

   localparam int AW_LO = $clog2(XLEN/8);

   wb_state_t       state_reg, state_next;
   logic [4:0]      ld_rd_reg, ld_rd_next;
   logic [2:0]      ld_fmt_reg, ld_fmt_next;
   logic [AW_LO-1:0] ld_addr_reg, ld_addr_next;
   logic            rf_we_reg, rf_we_next;
   logic [4:0]      rf_waddr_reg, rf_waddr_next;
   logic [XLEN-1:0] rf_wdata_reg, rf_wdata_next;
   logic            retired_reg, retired_next;
   logic [XLEN-1:0] link_data;
   logic [XLEN-1:0] align_data;

   // Link value wraps naturally at XLEN bits
   assign link_data = in_pc + XLEN'(LINK_INC);

   wb_load_align #(
      .XLEN (XLEN)
   ) u_align (
      .fmt     (ld_fmt_reg),
      .addr_lo (ld_addr_reg),
      .rdata   (mem_rdata),
      .result  (align_data)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= S_IDLE;
      else     state_reg <= state_next;
   end

   // Next state, load bookkeeping and writeback values
   always_comb begin
      state_next    = state_reg;
      ld_rd_next    = ld_rd_reg;
      ld_fmt_next   = ld_fmt_reg;
      ld_addr_next  = ld_addr_reg;
      rf_we_next    = 1'b0;
      retired_next  = 1'b0;
      rf_waddr_next = rf_waddr_reg;
      rf_wdata_next = rf_wdata_reg;
      case (state_reg)
         S_IDLE: begin
            if (in_valid) begin
               if (in_w_type == W_LOAD) begin
                  // mem_rvalid is deliberately not looked at in this cycle
                  ld_rd_next   = in_rd;
                  ld_fmt_next  = in_ld_fmt;
                  ld_addr_next = in_addr_lo;
                  state_next   = S_WAIT_MEM;
               end else begin
                  rf_we_next    = writes_rf(in_w_type) && (in_rd != 5'd0);
                  rf_waddr_next = in_rd;
                  retired_next  = 1'b1;
                  case (in_w_type)
                     W_ALU:   rf_wdata_next = in_rd_data;
                     W_LINK:  rf_wdata_next = link_data;
                     W_CSR:   rf_wdata_next = in_csr_data;
                     default: rf_wdata_next = rf_wdata_reg;
                  endcase
               end
            end
         end
         S_WAIT_MEM: begin
            if (mem_rvalid) begin
               rf_we_next    = (ld_rd_reg != 5'd0);
               rf_waddr_next = ld_rd_reg;
               rf_wdata_next = align_data;
               retired_next  = 1'b1;
               state_next    = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Latched load context and registered writeback outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ld_rd_reg    <= 5'd0;
         ld_fmt_reg   <= 3'd0;
         ld_addr_reg  <= '0;
         rf_we_reg    <= 1'b0;
         rf_waddr_reg <= 5'd0;
         rf_wdata_reg <= '0;
         retired_reg  <= 1'b0;
      end else begin
         ld_rd_reg    <= ld_rd_next;
         ld_fmt_reg   <= ld_fmt_next;
         ld_addr_reg  <= ld_addr_next;
         rf_we_reg    <= rf_we_next;
         rf_waddr_reg <= rf_waddr_next;
         rf_wdata_reg <= rf_wdata_next;
         retired_reg  <= retired_next;
      end
   end

   assign in_ready = (state_reg == S_IDLE);
   assign rf_we    = rf_we_reg;
   assign rf_waddr = rf_waddr_reg;
   assign rf_wdata = rf_wdata_reg;
   assign retired  = retired_reg;

`ifdef WB_INSTRET_EN
   logic [63:0] instret_reg;

   // Count each retirement on the same edge that raises the retired pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst)               instret_reg <= 64'd0;
      else if (retired_next) instret_reg <= instret_reg + 64'd1;
   end

   assign instret = instret_reg;
`else
   assign instret = 64'd0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed testbench for wb_stage with a cycle-stamped writeback scoreboard.
module tb_wb_stage;
   import wb_pkg::*;

   localparam int XLEN = 32;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_rd;
   logic [2:0]  in_w_type;
   logic [2:0]  in_ld_fmt;
   logic [1:0]  in_addr_lo;
   logic [31:0] in_rd_data;
   logic [31:0] in_pc;
   logic [31:0] in_csr_data;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        retired;
   logic [63:0] instret;

   typedef struct {
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic        chk_data;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   vectors     = 0;
   int   miscompares = 0;
   int   cyc         = 0;
   int   n_retired   = 0;

   typedef struct {
      logic [2:0]  fmt;
      logic [1:0]  addr;
      logic [31:0] data;
      logic [31:0] exp;
   } ld_vec_t;

   wb_stage #(
      .XLEN     (XLEN),
      .LINK_INC (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_rd       (in_rd),
      .in_w_type   (in_w_type),
      .in_ld_fmt   (in_ld_fmt),
      .in_addr_lo  (in_addr_lo),
      .in_rd_data  (in_rd_data),
      .in_pc       (in_pc),
      .in_csr_data (in_csr_data),
      .mem_rvalid  (mem_rvalid),
      .mem_rdata   (mem_rdata),
      .rf_we       (rf_we),
      .rf_waddr    (rf_waddr),
      .rf_wdata    (rf_wdata),
      .retired     (retired),
      .instret     (instret)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic we, input logic [4:0] waddr,
                           input logic [31:0] wdata, input logic chk_data);
      exp_t e;
      e.we       = we;
      e.waddr    = waddr;
      e.wdata    = wdata;
      e.chk_data = chk_data;
      e.cyc      = cyc + 1;
      sb.push_back(e);
   endtask

   // Present a non-load op for one cycle; in_valid stays high for back-to-back use
   task automatic drive(input logic [2:0] w, input logic [4:0] rd, input logic [31:0] rdd,
                        input logic [31:0] pc, input logic [31:0] csr,
                        input logic exp_we, input logic [31:0] exp_wdata, input logic chk);
      in_valid    = 1'b1;
      in_w_type   = w;
      in_rd       = rd;
      in_rd_data  = rdd;
      in_pc       = pc;
      in_csr_data = csr;
      check("in_ready_accept", {63'd0, in_ready}, 64'd1);
      push_exp(exp_we, rd, exp_wdata, chk);
      @(posedge clk); #1;
   endtask

   task automatic drive_load(input logic [4:0] rd, input logic [2:0] fmt,
                             input logic [1:0] addr, input logic rv_in_accept);
      in_valid   = 1'b1;
      in_w_type  = W_LOAD;
      in_rd      = rd;
      in_ld_fmt  = fmt;
      in_addr_lo = addr;
      mem_rvalid = rv_in_accept;
      mem_rdata  = 32'hDEAD_BEEF;
      check("in_ready_load", {63'd0, in_ready}, 64'd1);
      @(posedge clk); #1;
      in_valid   = 1'b0;
      mem_rvalid = 1'b0;
      in_ld_fmt  = 3'd0;
      in_addr_lo = 2'd0;
   endtask

   task automatic mem_return(input int wait_n, input logic [31:0] data,
                             input logic [4:0] rd, input logic [31:0] exp);
      for (int i = 0; i < wait_n; i++) begin
         check("in_ready_wait", {63'd0, in_ready}, 64'd0);
         @(posedge clk); #1;
      end
      check("in_ready_rvalid", {63'd0, in_ready}, 64'd0);
      mem_rdata  = data;
      mem_rvalid = 1'b1;
      push_exp(rd != 5'd0, rd, exp, 1'b1);
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   // Monitor: every retire pulse must match the next scoreboard entry on its exact cycle
   initial begin
      forever begin
         @(negedge clk);
         if (rst === 1'b1) begin
            n_retired = 0;
         end else begin
            if (rf_we === 1'b1 && retired !== 1'b1)
               check("we_without_retire", {63'd0, rf_we}, 64'd0);
            if (retired === 1'b1) begin
               n_retired++;
               $display("retire cyc=%0d we=%0b waddr=%0d wdata=%08h", cyc, rf_we, rf_waddr, rf_wdata);
               if (sb.size() == 0) begin
                  check("spurious_retire", {63'd0, retired}, 64'd0);
               end else begin
                  exp_t e;
                  e = sb.pop_front();
                  check("retire_cycle", 64'(cyc), 64'(e.cyc));
                  check("rf_we", {63'd0, rf_we}, {63'd0, e.we});
                  check("rf_waddr", {59'd0, rf_waddr}, {59'd0, e.waddr});
                  if (e.chk_data)
                     check("rf_wdata", {32'd0, rf_wdata}, {32'd0, e.wdata});
               end
            end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
               check("missing_retire", {63'd0, retired}, 64'd1);
               void'(sb.pop_front());
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      ld_vec_t lv[12];
      lv[0]  = '{LD_B,  2'd0, 32'h80FF_0000, 32'h0000_0000};
      lv[1]  = '{LD_BU, 2'd2, 32'h80FF_0000, 32'h0000_00FF};
      lv[2]  = '{LD_H,  2'd2, 32'h80FF_0000, 32'hFFFF_80FF};
      lv[3]  = '{LD_H,  2'd0, 32'h1234_8765, 32'hFFFF_8765};
      lv[4]  = '{LD_HU, 2'd0, 32'h1234_8765, 32'h0000_8765};
      lv[5]  = '{LD_BU, 2'd1, 32'h1234_8765, 32'h0000_0087};
      lv[6]  = '{LD_B,  2'd1, 32'h1234_8765, 32'hFFFF_FF87};
      lv[7]  = '{LD_W,  2'd1, 32'h1234_8765, 32'h1234_8765};
      lv[8]  = '{LD_WU, 2'd0, 32'h8765_4321, 32'h8765_4321};
      lv[9]  = '{LD_D,  2'd3, 32'h8765_4321, 32'h8765_4321};
      lv[10] = '{3'd7,  2'd2, 32'hF0E1_D2C3, 32'hF0E1_D2C3};
      lv[11] = '{LD_B,  2'd2, 32'h0071_0000, 32'h0000_0071};

      rst = 1'b1;
      in_valid = 1'b0; in_rd = 5'd0; in_w_type = W_NONE; in_ld_fmt = 3'd0;
      in_addr_lo = 2'd0; in_rd_data = 32'd0; in_pc = 32'd0; in_csr_data = 32'd0;
      mem_rvalid = 1'b0; mem_rdata = 32'd0;
      repeat (2) @(posedge clk);
      #1;

      // Reset state
      check("rst_in_ready", {63'd0, in_ready}, 64'd1);
      check("rst_rf_we", {63'd0, rf_we}, 64'd0);
      check("rst_rf_waddr", {59'd0, rf_waddr}, 64'd0);
      check("rst_rf_wdata", {32'd0, rf_wdata}, 64'd0);
      check("rst_retired", {63'd0, retired}, 64'd0);
      check("rst_instret", instret, 64'd0);
      rst = 1'b0;

      // ALU writeback
      drive(W_ALU, 5'd5, 32'h0000_1234, 32'd0, 32'd0, 1'b1, 32'h0000_1234, 1'b1);
      idle(1);

      // LINK with wrap, then LINK to x0
      drive(W_LINK, 5'd1, 32'h1111_1111, 32'hFFFF_FFFC, 32'd0, 1'b1, 32'h0000_0000, 1'b1);
      drive(W_LINK, 5'd0, 32'h2222_2222, 32'h0000_0100, 32'd0, 1'b0, 32'h0000_0104, 1'b1);
      idle(1);

      // LB with mem_rvalid asserted in the accept cycle (must be ignored),
      // then LHU accepted on the cycle the first load writes back
      drive_load(5'd7, LD_B, 2'd3, 1'b1);
      mem_return(2, 32'h80FF_0000, 5'd7, 32'hFFFF_FF80);
      drive_load(5'd8, LD_HU, 2'd2, 1'b0);
      mem_return(1, 32'h80FF_0000, 5'd8, 32'h0000_80FF);
      idle(1);

      // Load alignment table
      for (int i = 0; i < 12; i++) begin
         drive_load(5'(10 + i), lv[i].fmt, lv[i].addr, 1'b0);
         mem_return(i % 3, lv[i].data, 5'(10 + i), lv[i].exp);
      end
      // Load to x0 retires without writing
      drive_load(5'd0, LD_W, 2'd0, 1'b0);
      mem_return(1, 32'hABCD_0123, 5'd0, 32'hABCD_0123);
      idle(1);

      // Back-to-back ALU, CSR, NONE, type 7
      drive(W_ALU, 5'd3, 32'h0000_AAAA, 32'd0, 32'd0, 1'b1, 32'h0000_AAAA, 1'b1);
      drive(W_CSR, 5'd4, 32'h0000_9999, 32'd0, 32'h0000_5555, 1'b1, 32'h0000_5555, 1'b1);
      drive(W_NONE, 5'd6, 32'h0000_7777, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
      drive(3'd7, 5'd9, 32'h0000_6666, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
      drive(W_ALU, 5'd12, 32'h0000_CAFE, 32'd0, 32'd0, 1'b1, 32'h0000_CAFE, 1'b1);
      idle(3);

      // Outputs hold with no traffic
      check("hold_rf_waddr", {59'd0, rf_waddr}, 64'd12);
      check("hold_rf_wdata", {32'd0, rf_wdata}, 64'h0000_CAFE);
      check("hold_rf_we", {63'd0, rf_we}, 64'd0);

      // A few random ALU ops at full rate
      for (int i = 0; i < 6; i++) begin
         logic [4:0]  r;
         logic [31:0] d;
         r = 5'($urandom_range(0, 31));
         d = $urandom;
         drive(W_ALU, r, d, 32'd0, 32'd0, r != 5'd0, d, 1'b1);
      end
      idle(2);

      // instret tracks the retirements seen since reset
`ifdef WB_INSTRET_EN
      check("instret_count", instret, 64'(n_retired));
`else
      check("instret_tied", instret, 64'd0);
`endif

      // Reset while waiting on memory drops the load
      drive_load(5'd9, LD_W, 2'd0, 1'b0);
      @(posedge clk); #1;
      check("wait_in_ready", {63'd0, in_ready}, 64'd0);
      rst = 1'b1;
      #1;
      check("rst_wait_in_ready", {63'd0, in_ready}, 64'd1);
      check("rst_wait_rf_we", {63'd0, rf_we}, 64'd0);
      check("rst_wait_rf_wdata", {32'd0, rf_wdata}, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      mem_rdata  = 32'h5A5A_5A5A;
      mem_rvalid = 1'b1;
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      idle(2);
      check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
      check("post_rst_rf_we", {63'd0, rf_we}, 64'd0);

      // Operation resumes; ten retirements including x0 and NONE
      for (int i = 0; i < 10; i++) begin
         if (i == 3)
            drive(W_ALU, 5'd0, 32'h0000_0033, 32'd0, 32'd0, 1'b0, 32'h0000_0033, 1'b1);
         else if (i == 6)
            drive(W_NONE, 5'd2, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
         else
            drive(W_ALU, 5'(i + 1), 32'(i * 16 + 1), 32'd0, 32'd0, 1'b1, 32'(i * 16 + 1), 1'b1);
      end
      idle(2);
`ifdef WB_INSTRET_EN
      check("instret_ten", instret, 64'd10);
`else
      check("instret_ten_tied", instret, 64'd0);
`endif
      check("retired_after_rst", 64'(n_retired), 64'd10);
      check("scoreboard_empty", 64'(sb.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
